sync_gray_ptr_rx: RTL and testbench

//  Receive-side pointer synchroniser for the async FIFO family, next generation of the 2-flop w2r sync.

---
 rtl/sync_ptr_pkg.sv | 31 +++
 rtl/sync_gray_lane.sv | 68 ++++++
 rtl/sync_gray_ptr_rx.sv | 73 +++++++
 tb/tb_sync_gray_ptr_rx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sync_ptr_pkg.sv
// Shared helpers and limits for the gray-pointer receive synchroniser family.
// Functions operate on a fixed-width word; narrower pointers are zero-extended, which leaves results unchanged.
package sync_ptr_pkg;

    localparam int MIN_SYNC_STAGES = 2;
    localparam int MAX_SYNC_STAGES = 4;
    localparam int MAX_PTR_W       = 32;

    typedef logic [MAX_PTR_W-1:0] ptr_word_t;

    // Prefix XOR from the MSB down, built with doubling shifts.
    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b = g;
        for (int s = 1; s < MAX_PTR_W; s = s * 2) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction

    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic hamming_gt1(input ptr_word_t a, input ptr_word_t b);
        ptr_word_t x;
        x = a ^ b;
        return (x & (x - 1'b1)) != '0;
    endfunction

endpackage

// File: rtl/sync_gray_lane.sv
// One channel: gray synchroniser chain, registered binary decode, update pulse and modular delta.
// Optional gray-code violation flag when SYNC_GRAY_CHECK_EN is defined.
module sync_gray_lane
    import sync_ptr_pkg::*;
#(
    parameter int PW          = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [PW-1:0] wptr,
`ifdef SYNC_GRAY_CHECK_EN
    input  logic          warm,
    input  logic          err_clr,
    output logic          gray_err,
`endif
    output logic [PW-1:0] gray,
    output logic [PW-1:0] bin,
    output logic          upd,
    output logic [PW-1:0] delta
);

    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] next_bin;
    logic          changed;

    assign gray     = sync_q[SYNC_STAGES-1];
    assign next_bin = PW'(gray2bin(ptr_word_t'(gray)));
    assign changed  = (next_bin != bin);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            bin   <= '0;
            upd   <= 1'b0;
            delta <= '0;
        end else begin
            sync_q[0] <= wptr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            bin   <= next_bin;
            upd   <= changed;
            // PW-bit subtraction wraps, so a 2^PW-1 -> 0 step yields 1.
            delta <= changed ? PW'(next_bin - bin) : '0;
        end
    end

`ifdef SYNC_GRAY_CHECK_EN
    logic violation;

    // The value about to enter the last stage is compared against the current synced value.
    assign violation = warm && hamming_gt1(ptr_word_t'(sync_q[SYNC_STAGES-2]), ptr_word_t'(gray));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gray_err <= 1'b0;
        end else if (violation) begin
            gray_err <= 1'b1;
        end else if (err_clr) begin
            gray_err <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/sync_gray_ptr_rx.sv
// Read-domain receiver for CHANNELS gray-coded write pointers of an async FIFO.
// Define SYNC_GRAY_CHECK_EN to add the err_clr/gray_err gray-code violation checker.
module sync_gray_ptr_rx
    import sync_ptr_pkg::*;
#(
    parameter  int ADDRSIZE    = 4,
    parameter  int SYNC_STAGES = 2,
    parameter  int CHANNELS    = 1,
    localparam int PW          = ADDRSIZE + 1
) (
    input  logic                   rclk,
    input  logic                   rrst_n,
    input  logic [CHANNELS*PW-1:0] wptr,
    output logic [CHANNELS*PW-1:0] rq_wptr_gray,
    output logic [CHANNELS*PW-1:0] rq_wptr_bin,
    output logic [CHANNELS-1:0]    rq_wptr_upd,
    output logic [CHANNELS*PW-1:0] rq_wptr_delta
`ifdef SYNC_GRAY_CHECK_EN
    ,
    input  logic                   err_clr,
    output logic [CHANNELS-1:0]    gray_err
`endif
);

    generate
        if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_stages
            $error("sync_gray_ptr_rx: SYNC_STAGES=%0d outside legal range 2..4", SYNC_STAGES);
        end
        if (CHANNELS < 1) begin : g_bad_channels
            $error("sync_gray_ptr_rx: CHANNELS must be at least 1");
        end
    endgenerate

`ifdef SYNC_GRAY_CHECK_EN
    localparam int WARM_CNT = SYNC_STAGES + 1;
    localparam int CW       = $clog2(WARM_CNT + 1);

    logic [CW-1:0] warm_cnt;
    logic          warm;

    assign warm = (warm_cnt == CW'(WARM_CNT));

    // Checks stay masked until the chain has flushed its reset zeros.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            warm_cnt <= '0;
        end else if (!warm) begin
            warm_cnt <= warm_cnt + 1'b1;
        end
    end
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        sync_gray_lane #(
            .PW          (PW),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_lane (
            .clk      (rclk),
            .rst_n    (rrst_n),
            .wptr     (wptr[c*PW +: PW]),
`ifdef SYNC_GRAY_CHECK_EN
            .warm     (warm),
            .err_clr  (err_clr),
            .gray_err (gray_err[c]),
`endif
            .gray     (rq_wptr_gray[c*PW +: PW]),
            .bin      (rq_wptr_bin[c*PW +: PW]),
            .upd      (rq_wptr_upd[c]),
            .delta    (rq_wptr_delta[c*PW +: PW])
        );
    end

endmodule

// File: tb/tb_sync_gray_ptr_rx.sv
// Self-checking bench for sync_gray_ptr_rx: one 2-stage single-channel instance and one 3-stage dual-channel instance.
// Expected outputs are queued when inputs are driven and popped as the pipeline delivers them.
module tb_sync_gray_ptr_rx;

    localparam int PW = 5;
    localparam int SA = 2;
    localparam int SB = 3;

    typedef struct packed {
        logic [PW-1:0] gray;
        logic [PW-1:0] bin;
        logic          upd;
        logic [PW-1:0] delta;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            err_clr;
    logic [PW-1:0]   wptr_a;
    logic [2*PW-1:0] wptr_b;

    logic [PW-1:0]   gray_a, bin_a, delta_a;
    logic            upd_a;
    logic [2*PW-1:0] gray_b, bin_b, delta_b;
    logic [1:0]      upd_b;
    logic            gerr_a;
    logic [1:0]      gerr_b;

    sync_gray_ptr_rx #(.ADDRSIZE(4), .SYNC_STAGES(SA), .CHANNELS(1)) dut_a (
        .rclk          (clk),
        .rrst_n        (rst_n),
        .wptr          (wptr_a),
        .rq_wptr_gray  (gray_a),
        .rq_wptr_bin   (bin_a),
        .rq_wptr_upd   (upd_a),
        .rq_wptr_delta (delta_a)
`ifdef SYNC_GRAY_CHECK_EN
        ,
        .err_clr       (err_clr),
        .gray_err      (gerr_a)
`endif
    );

    sync_gray_ptr_rx #(.ADDRSIZE(4), .SYNC_STAGES(SB), .CHANNELS(2)) dut_b (
        .rclk          (clk),
        .rrst_n        (rst_n),
        .wptr          (wptr_b),
        .rq_wptr_gray  (gray_b),
        .rq_wptr_bin   (bin_b),
        .rq_wptr_upd   (upd_b),
        .rq_wptr_delta (delta_b)
`ifdef SYNC_GRAY_CHECK_EN
        ,
        .err_clr       (err_clr),
        .gray_err      (gerr_b)
`endif
    );

`ifndef SYNC_GRAY_CHECK_EN
    assign gerr_a = 1'b0;
    assign gerr_b = 2'b00;
`endif

    exp_t          qa[$];
    exp_t          qb0[$];
    exp_t          qb1[$];
    logic [PW-1:0] last_a, last_b0, last_b1;
    int            n_chk  = 0;
    int            n_fail = 0;

    // Bit-serial decode, independent of the shift-doubling form in the design.
    function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [PW-1:0] b2g(input int v);
        logic [PW-1:0] b;
        b = PW'(v);
        return b ^ (b >> 1);
    endfunction

    function automatic exp_t mk(input logic [PW-1:0] g, input logic [PW-1:0] last);
        exp_t e;
        e.gray  = g;
        e.bin   = g2b(g);
        e.upd   = (e.bin != last);
        e.delta = e.upd ? PW'(e.bin - last) : '0;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic init_model();
        qa.delete();
        qb0.delete();
        qb1.delete();
        for (int i = 0; i < SA; i++) qa.push_back(mk('0, '0));
        for (int i = 0; i < SB; i++) begin
            qb0.push_back(mk('0, '0));
            qb1.push_back(mk('0, '0));
        end
        last_a  = '0;
        last_b0 = '0;
        last_b1 = '0;
    endtask

    // Called just after a negedge: drive, queue expectations, then check after the next posedge.
    task automatic step(input logic [PW-1:0] a, input logic [PW-1:0] b0, input logic [PW-1:0] b1);
        exp_t e;
        wptr_a = a;
        wptr_b = {b1, b0};
        qa.push_back(mk(a, last_a));    last_a  = g2b(a);
        qb0.push_back(mk(b0, last_b0)); last_b0 = g2b(b0);
        qb1.push_back(mk(b1, last_b1)); last_b1 = g2b(b1);
        @(posedge clk);
        #1;
        e = qa.pop_front();
        check("a_bin",   32'(bin_a),   32'(e.bin));
        check("a_upd",   32'(upd_a),   32'(e.upd));
        check("a_delta", 32'(delta_a), 32'(e.delta));
        check("a_gray",  32'(gray_a),  32'(qa[0].gray));
        e = qb0.pop_front();
        check("b0_bin",   32'(bin_b[0 +: PW]),   32'(e.bin));
        check("b0_upd",   32'(upd_b[0]),         32'(e.upd));
        check("b0_delta", 32'(delta_b[0 +: PW]), 32'(e.delta));
        check("b0_gray",  32'(gray_b[0 +: PW]),  32'(qb0[0].gray));
        e = qb1.pop_front();
        check("b1_bin",   32'(bin_b[PW +: PW]),   32'(e.bin));
        check("b1_upd",   32'(upd_b[1]),          32'(e.upd));
        check("b1_delta", 32'(delta_b[PW +: PW]), 32'(e.delta));
        check("b1_gray",  32'(gray_b[PW +: PW]),  32'(qb1[0].gray));
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a_gray"},  32'(gray_a),  32'd0);
        check({tag, "_a_bin"},   32'(bin_a),   32'd0);
        check({tag, "_a_upd"},   32'(upd_a),   32'd0);
        check({tag, "_a_delta"}, 32'(delta_a), 32'd0);
        check({tag, "_b_gray"},  32'(gray_b),  32'd0);
        check({tag, "_b_bin"},   32'(bin_b),   32'd0);
        check({tag, "_b_upd"},   32'(upd_b),   32'd0);
        check({tag, "_b_delta"}, 32'(delta_b), 32'd0);
        check({tag, "_gerr"},    32'({gerr_b, gerr_a}), 32'd0);
    endtask

    initial begin
        rst_n   = 1'b1;
        err_clr = 1'b0;
        wptr_a  = '0;
        wptr_b  = '0;
        #1 rst_n = 1'b0;
        wptr_a = b2g(7);
        wptr_b = {b2g(5), b2g(3)};
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset");

        // Release at a negedge and start stepping from a zero history.
        @(negedge clk);
        rst_n = 1'b1;
        init_model();
        repeat (3) step('0, '0, '0);

        // a: 0 -> gray 1; b: ch0 gray 0->1, ch1 gray 0->3 in the same cycle.
        repeat (5) step(b2g(1), 5'b00001, 5'b00011);

        // Walk a around the full gray sequence, ending with the 31 -> 0 wrap.
        for (int v = 2; v < 32; v++) step(b2g(v), 5'b00001, 5'b00011);
        repeat (4) step(b2g(0), 5'b00001, 5'b00011);
        check("walk_gerr_a", 32'(gerr_a), 32'd0);

        // Climb to 9, then reset mid-stream without a clock edge.
        for (int v = 1; v <= 9; v++) step(b2g(v), b2g(v), 5'b00011);
        repeat (4) step(b2g(9), b2g(9), 5'b00011);
        check("pre_rst_bin", 32'(bin_a), 32'd9);
        #2 rst_n = 1'b0;
        #1 check_all_zero("mid_rst");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        init_model();
        repeat (6) step(b2g(9), b2g(9), b2g(9));
        check("post_rst_bin", 32'(bin_a), 32'd9);
        check("post_rst_gerr", 32'({gerr_b, gerr_a}), 32'd0);

`ifdef SYNC_GRAY_CHECK_EN
        // Return to 0 along legal gray steps, then force a two-bit jump.
        for (int v = 8; v >= 0; v--) step(b2g(v), b2g(v), b2g(v));
        repeat (3) step('0, '0, '0);
        check("legal_gerr_a", 32'(gerr_a), 32'd0);
        repeat (4) step(5'b00011, '0, '0);
        check("jump_gerr_a", 32'(gerr_a), 32'd1);
        err_clr = 1'b1;
        step(5'b00011, '0, '0);
        err_clr = 1'b0;
        step(5'b00011, '0, '0);
        check("clr_gerr_a", 32'(gerr_a), 32'd0);
        err_clr = 1'b1;
        step('0, '0, '0);
        step('0, '0, '0);
        check("set_wins_gerr_a", 32'(gerr_a), 32'd1);
        err_clr = 1'b0;
        repeat (3) step('0, '0, '0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
